// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped instruction cache with zero-latency hit path and a
//             two-state (IDLE / REFILL) line refill engine. Lines are filled
//             one 32-bit word per memory acknowledge, beat 0 first.
//  Revision : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int NSETS  = 8,   // direct-mapped lines, power of two, >= 2
    parameter int LWORDS = 4    // 32-bit words per line, power of two, >= 2
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        missF,
    input  logic        inval,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Address field widths: [1:0] byte | offset | index | tag
    localparam int c_offW = $clog2(LWORDS);
    localparam int c_idxW = $clog2(NSETS);
    localparam int c_tagW = 30 - c_offW - c_idxW;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    localparam logic [c_offW-1:0] c_lastBeat = c_offW'(LWORDS - 1);

    // Storage: data and tags are never reset; only valid bits are.
    logic [31:0]       r_data [NSETS][LWORDS];
    logic [c_tagW-1:0] r_tags [NSETS];
    logic [NSETS-1:0]  r_valid;

    logic [0:0]        r_state;
    logic [c_tagW-1:0] r_refTag;
    logic [c_idxW-1:0] r_refIdx;
    logic [c_offW-1:0] r_beat;

    logic [c_offW-1:0] w_offset;
    logic [c_idxW-1:0] w_index;
    logic [c_tagW-1:0] w_tag;
    logic              w_hit;
    logic              w_beatAck;
    logic              w_lastAck;
    logic              w_unusedByteBits;

    assign w_offset = pcF[2 +: c_offW];
    assign w_index  = pcF[2 + c_offW +: c_idxW];
    assign w_tag    = pcF[31 -: c_tagW];

    // Byte-within-word bits never participate in a lookup.
    assign w_unusedByteBits = ^pcF[1:0];

    // Hit is only meaningful in IDLE; every REFILL cycle reports a miss.
    assign w_hit = (r_state == IDLE) && r_valid[w_index] && (r_tags[w_index] == w_tag);

    assign instrF = w_hit ? r_data[w_index][w_offset] : 32'h0;
    assign missF  = ~w_hit;

    assign mem_req  = (r_state == REFILL);
    assign mem_addr = mem_req ? {r_refTag, r_refIdx, r_beat, 2'b00} : 32'h0;

    // An ack only counts while a request is outstanding.
    assign w_beatAck = mem_req && mem_ack;
    assign w_lastAck = w_beatAck && (r_beat == c_lastBeat);

    // Refill controller: latch the missing line, walk the beats, return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_refTag <= '0;
            r_refIdx <= '0;
            r_beat   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_state  <= REFILL;
                        r_refTag <= w_tag;
                        r_refIdx <= w_index;
                        r_beat   <= '0;
                    end
                end
                REFILL: begin
                    if (w_beatAck) begin
                        r_beat <= r_beat + c_offW'(1);
                        if (w_lastAck) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Valid bits: invalidate clears all, but a line completing this edge wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            if (inval) begin
                r_valid <= '0;
            end
            if (w_lastAck) begin
                r_valid[r_refIdx] <= 1'b1;
            end
        end
    end

    // Data and tag write port, driven only by accepted refill beats.
    always_ff @(posedge clk) begin
        if (w_beatAck) begin
            r_data[r_refIdx][r_beat] <= mem_rdata;
        end
        if (w_lastAck) begin
            r_tags[r_refIdx] <= r_refTag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache
//  Purpose  : Self-checking bench for icache. A line-level behavioural model
//             predicts every output each cycle; directed scenarios pin the
//             model with hand-computed values, then randomized traffic runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

    localparam int NSETS  = 8;
    localparam int LWORDS = 4;
    localparam int LINEB  = LWORDS * 4;

    logic        clk;
    logic        reset;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        missF;
    logic        inval;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    icache #(.NSETS(NSETS), .LWORDS(LWORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .pcF      (pcF),
        .instrF   (instrF),
        .missF    (missF),
        .inval    (inval),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int lineIdx(input logic [31:0] a);
        return int'((a / LINEB) % NSETS);
    endfunction

    function automatic logic [31:0] lineTag(input logic [31:0] a);
        return a / (LINEB * NSETS);
    endfunction

    function automatic int wordOff(input logic [31:0] a);
        return int'((a / 4) % LWORDS);
    endfunction

    assign mem_rdata = memWord(mem_addr);

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (line granularity) ----------------
    bit          mValid [NSETS];
    logic [31:0] mTag   [NSETS];
    logic [31:0] mData  [NSETS][LWORDS];
    bit          mBusy;
    logic [31:0] mBase;
    int          mBeat;
    bit          chkOn = 1'b0;

    task automatic clearValid();
        for (int i = 0; i < NSETS; i++) mValid[i] = 1'b0;
    endtask

    function automatic bit modelHit(input logic [31:0] a);
        return mValid[lineIdx(a)] && (mTag[lineIdx(a)] == lineTag(a));
    endfunction

    task automatic modelStep();
        bit h;
        if (!reset) begin
            clearValid();
            mBusy = 1'b0;
            mBeat = 0;
        end else if (!mBusy) begin
            h = modelHit(pcF);
            if (inval) clearValid();
            if (!h) begin
                mBusy = 1'b1;
                mBase = (pcF / LINEB) * LINEB;
                mBeat = 0;
            end
        end else begin
            if (inval) clearValid();
            if (mem_ack) begin
                mData[lineIdx(mBase)][mBeat] = memWord(mBase + 32'(mBeat * 4));
                mBeat++;
                if (mBeat == LWORDS) begin
                    mValid[lineIdx(mBase)] = 1'b1;
                    mTag[lineIdx(mBase)]   = lineTag(mBase);
                    mBusy = 1'b0;
                end
            end
        end
    endtask

    initial begin
        mBusy = 1'b0;
        mBeat = 0;
        clearValid();
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Per-cycle comparison of all outputs against the model.
    task automatic compareOutputs();
        logic [31:0] eInstr, eAddr;
        logic        eMiss, eReq;
        if (!reset) begin
            eMiss = 1'b1; eInstr = 32'h0; eReq = 1'b0; eAddr = 32'h0;
        end else if (mBusy) begin
            eMiss = 1'b1; eInstr = 32'h0; eReq = 1'b1; eAddr = mBase + 32'(mBeat * 4);
        end else if (modelHit(pcF)) begin
            eMiss = 1'b0; eInstr = mData[lineIdx(pcF)][wordOff(pcF)]; eReq = 1'b0; eAddr = 32'h0;
        end else begin
            eMiss = 1'b1; eInstr = 32'h0; eReq = 1'b0; eAddr = 32'h0;
        end
        check("missF", 32'(missF), 32'(eMiss));
        check("instrF", instrF, eInstr);
        check("mem_req", 32'(mem_req), 32'(eReq));
        check("mem_addr", mem_addr, eAddr);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chkOn) compareOutputs();
        end
    end

    // ---------------- memory responder ----------------
    int ackDelay = 0;
    bit ackRand  = 1'b0;

    initial begin
        int waitCnt;
        waitCnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ackRand) begin
                mem_ack = 1'($urandom_range(0, 1));
            end else if (mem_req) begin
                if (waitCnt >= ackDelay) begin
                    mem_ack = 1'b1;
                    waitCnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                mem_ack = 1'b0;
                waitCnt = 0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [31:0] addrLog[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present pc now and wait for the hit; counts miss cycles, logs accepted beats.
    task automatic fetch(input logic [31:0] pc, output int nMiss);
        bit done;
        done  = 1'b0;
        nMiss = 0;
        pcF   = pc;
        addrLog.delete();
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) addrLog.push_back(mem_addr);
            if (!missF) done = 1'b1;
            else nMiss++;
        end
        if (!done) check("fetch_timeout", 32'h0, 32'h1);
    endtask

    task automatic checkBeats(input string name, input logic [31:0] base);
        check({name, "_beats"}, 32'(addrLog.size()), 32'(LWORDS));
        for (int i = 0; i < LWORDS && i < addrLog.size(); i++)
            check({name, "_addr"}, addrLog[i], base + 32'(4 * i));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit found;
        reset = 1'b0;
        inval = 1'b0;
        pcF   = 32'h40;
        step();
        step();
        chkOn = 1'b1;
        @(negedge clk);
        check("rst_missF", 32'(missF), 32'h1);
        check("rst_instrF", instrF, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // Cold miss
        step(); reset = 1'b1;
        fetch(32'h40, n);
        check("cold_miss_cycles", 32'(n), 32'd5);
        checkBeats("cold", 32'h40);
        check("cold_instr", instrF, 32'h0040FFBF);

        // Sequential hits
        step(); fetch(32'h44, n);
        check("seq44_miss", 32'(n), 32'd0);
        check("seq44_instr", instrF, 32'h0044FFBB);
        step(); fetch(32'h48, n);
        check("seq48_miss", 32'(n), 32'd0);
        check("seq48_instr", instrF, 32'h0048FFB7);
        step(); fetch(32'h4C, n);
        check("seq4C_miss", 32'(n), 32'd0);
        check("seq4C_instr", instrF, 32'h004CFFB3);
        check("seq_no_beats", 32'(addrLog.size()), 32'd0);

        // Conflict eviction
        step(); fetch(32'h840, n);
        check("conf1_miss", 32'(n), 32'd5);
        check("conf1_instr", instrF, 32'h0840F7BF);
        step(); fetch(32'h40, n);
        check("conf2_miss", 32'(n), 32'd5);
        step(); fetch(32'h840, n);
        check("conf3_miss", 32'(n), 32'd5);

        // Wait states
        ackDelay = 3;
        step(); fetch(32'h100, n);
        check("wait_miss", 32'(n), 32'd17);
        checkBeats("wait", 32'h100);
        check("wait_instr", instrF, 32'h0100FEFF);
        ackDelay = 0;

        // Invalidate one cycle after a hit
        step(); fetch(32'h40, n);
        step(); fetch(32'h40, n);
        check("inv_prehit", 32'(n), 32'd0);
        step(); inval = 1'b1;
        step(); inval = 1'b0;
        fetch(32'h40, n);
        check("inv_refetch", 32'(n), 32'd5);

        // Invalidate coinciding with the final-beat edge
        step(); fetch(32'h100, n);
        step(); pcF = 32'h30;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (mem_req && mem_addr == 32'h3C) found = 1'b1;
        end
        check("inv_last_found", 32'(found), 32'h1);
        inval = 1'b1;
        step(); inval = 1'b0;
        fetch(32'h30, n);
        check("inv_last_kept", 32'(n), 32'd0);
        check("inv_last_instr", instrF, 32'h0030FFCF);
        step(); fetch(32'h100, n);
        check("inv_last_other", 32'(n), 32'd5);

        // Reset during beat 2
        step(); pcF = 32'h500;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (mem_req && mem_addr == 32'h508) found = 1'b1;
        end
        check("midrst_found", 32'(found), 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_req", 32'(mem_req), 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_miss", 32'(missF), 32'h1);
        step(); step();
        reset = 1'b1;
        fetch(32'h500, n);
        check("midrst_miss_cycles", 32'(n), 32'd5);
        checkBeats("midrst", 32'h500);

        // Randomized traffic against the model
        ackRand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 3) == 0)
                pcF = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2)
                      | 32'($urandom_range(0, 3));
            inval = ($urandom_range(0, 15) == 0);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
        end
        ackRand = 1'b0;
        reset   = 1'b1;
        inval   = 1'b0;
        for (int i = 0; i < 30; i++) step();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have a parameter NSETS, default 8, meaning the number of direct-mapped lines, power of two, at least 2.
REQ-002 The module SHALL have a parameter LWORDS, default 4, meaning the 32-bit words per line, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pcF  input  32  fetch address from the datapath's PC register.
REQ-006 instrF  output  32  instruction delivered to the datapath's fetch/decode register.
REQ-007 missF  output  1  high while instrF is not valid; the datapath stalls F/D on it.
REQ-008 inval  input  1  synchronous request to invalidate all lines.
REQ-009 mem_req  output  1  refill read request to the instruction memory.
REQ-010 mem_addr  output  32  word-aligned refill address.
REQ-011 mem_ack  input  1  one beat of mem_rdata is valid this cycle.
REQ-012 mem_rdata  input  32  refill data.

Function
REQ-013 The address split SHALL be: pcF[1:0] ignored; offset = next log2(LWORDS) bits; index = next log2(NSETS) bits; tag = the remaining upper bits (defaults: [3:2], [6:4], [31:7]).
REQ-014 Storage SHALL be NSETS x LWORDS data words, plus one tag and one valid bit per line.
REQ-015 The FSM SHALL have exactly two states, IDLE and REFILL.
REQ-016 In IDLE, hit = valid[index] AND tag[index] == tag(pcF), evaluated combinationally.
REQ-017 On hit: instrF = data[index][offset] in the same cycle, missF = 0, zero-cycle latency.
REQ-018 Otherwise instrF SHALL be 32'h0 and missF = 1 (IDLE miss, and every REFILL cycle).
REQ-019 IDLE with a miss SHALL move to REFILL at the next edge, latching tag and index of pcF and clearing the beat counter to 0.
REQ-020 In REFILL, mem_req = 1 and mem_addr = {latched tag, latched index, beat, 2'b00}; both SHALL stay stable until mem_ack.
REQ-021 Each cycle with mem_req = 1 and mem_ack = 1 SHALL write mem_rdata to data[latched index][beat] and increment beat; an ack in the same cycle as the req is legal (zero wait).
REQ-022 On the ack of beat LWORDS-1, the block SHALL write tag, set valid, and return to IDLE; mem_req SHALL be 0 in the following cycle.
REQ-023 The refill miss SHALL resolve as a hit on the first IDLE cycle after the refill, provided pcF is unchanged. Miss penalty = 1 + sum of beat latencies.
REQ-024 mem_ack while mem_req = 0 SHALL be ignored.
REQ-025 pcF changes during REFILL SHALL not alter the in-flight refill; pcF is re-looked-up on return to IDLE.
REQ-026 inval = 1 SHALL clear all valid bits at the next edge in either state; tag and data SHALL be untouched.
REQ-027 inval during REFILL SHALL not abort the refill. If it coincides with the final-beat edge, the refilled line SHALL end valid; every other line ends invalid.
REQ-028 mem_addr SHALL be 32'h0 whenever mem_req = 0.

Reset
REQ-029 reset low SHALL force at once: state IDLE, all valid = 0, beat = 0, mem_req = 0, mem_addr = 0.
REQ-030 Output values during reset: missF = 1, instrF = 0.
REQ-031 Data and tag arrays SHALL NOT be reset.
REQ-032 reset asserted mid-REFILL SHALL abandon the refill; no line becomes valid.
REQ-033 The first edge after reset release SHALL begin normal operation.

Verification
REQ-034 Cold miss. Stimulus: release reset, pcF = 0x00000040, mem_ack high every cycle. Response: missF = 1 for 5 cycles; mem_addr sequence 0x40, 0x44, 0x48, 0x4C; then missF = 0 with instrF = the beat-0 word.
REQ-035 Sequential hits. Stimulus: after REQ-034, step pcF through 0x44, 0x48, 0x4C. Response: missF = 0 every cycle, no mem_req, instrF matches the beat data.
REQ-036 Conflict eviction. Stimulus: fetch 0x40, then 0x840 (same index, different tag), then 0x40 again. Response: three refills; after the third, 0x840 misses again.
REQ-037 Wait states. Stimulus: mem_ack delayed 3 cycles per beat. Response: mem_addr stable during the waits, missF high for 17 cycles, correct data.
REQ-038 Invalidate. Stimulus: assert inval one cycle after a hit on 0x40, then fetch 0x40. Response: miss, refill. Stimulus: inval on the final-beat edge. Response: that line valid, others invalid.
REQ-039 Reset mid-refill. Stimulus: reset low during beat 2, release, fetch the same address. Response: mem_req drops at once; a full 4-beat refill is reissued from beat 0.
